life_ctrl: RTL and testbench

- Sequencer between the host/switch interface and the Game-of-Life PE array.
- Accepts host operations (clear, write cell, read cell, run N generations, scan whole board) over a valid/ready handshake.
- Translates each operation into timed array commands (cmd, address, state_in).
- Returns cell states on a valid/ready read stream and counts completed generations.

---
 rtl/life_pkg.sv | 41 ++++
 rtl/life_scan_addr.sv | 53 +++++
 rtl/life_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_life_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// life_pkg -- shared command/op/state types and sizing helper for the life array controller.
// Rev 1.0
package life_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    OP_CLEAR = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_RUN   = 3'd3,
    OP_SCAN  = 3'd4
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLEAR     = 4'd1,
    S_WRITE     = 4'd2,
    S_RD_ADDR   = 4'd3,
    S_RD_WAIT   = 4'd4,
    S_RD_OUT    = 4'd5,
    S_STEP      = 4'd6,
    S_SETTLE    = 4'd7,
    S_SCAN_ADDR = 4'd8,
    S_SCAN_WAIT = 4'd9,
    S_SCAN_OUT  = 4'd10
  } ctrl_state_t;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_scan_addr.sv
`default_nettype none
// life_scan_addr -- raster x/y cell counter (x fastest) used while scanning the whole board.
// Rev 1.0
module life_scan_addr
  import life_pkg::*;
#(
  parameter  int ARR_W = 8,
  parameter  int ARR_H = 8,
  localparam int XW    = $clog2(ARR_W),
  localparam int YW    = $clog2(ARR_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_advance,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last,
  output logic          o_wrap
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end = (r_x == XW'(ARR_W - 1));
  assign w_y_end = (r_y == YW'(ARR_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;
  assign o_wrap = i_advance && w_x_end && w_y_end;

endmodule
`default_nettype wire

// File: rtl/life_ctrl.sv
`default_nettype none
// life_ctrl -- sequences host clear/write/read/run/scan operations into timed PE-array commands.
// Rev 1.0
module life_ctrl
  import life_pkg::*;
#(
  parameter  int ARR_W    = 8,
  parameter  int ARR_H    = 8,
  parameter  int READ_LAT = 1,
  parameter  int SETTLE   = 2,
  parameter  int GEN_W    = 16,
  localparam int XW       = $clog2(ARR_W),
  localparam int YW       = $clog2(ARR_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [2:0]       i_op_code,
  input  logic [XW-1:0]    i_op_x,
  input  logic [YW-1:0]    i_op_y,
  input  logic [GEN_W-1:0] i_op_data,
  input  logic             i_stop,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic             o_rd_data,
  output logic             o_rd_last,
  output logic             o_busy,
  output logic [GEN_W-1:0] o_gen_count,
  output logic [1:0]       o_arr_cmd,
  output logic [XW-1:0]    o_arr_adr_x,
  output logic [YW-1:0]    o_arr_adr_y,
  output logic             o_arr_state_in,
  input  logic             i_arr_state_out
);

  localparam int LAT_W = cnt_w(READ_LAT);
  localparam int SET_W = cnt_w(SETTLE);

  ctrl_state_t      r_state;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic             r_bit;
  logic             r_ok;
  logic [GEN_W-1:0] r_rem;
  logic [LAT_W-1:0] r_lat;
  logic [SET_W-1:0] r_set;
  logic [GEN_W-1:0] r_gen;

  logic             w_accept;
  logic             w_in_range;
  logic             w_lat_done;
  logic             w_gen_done;
  logic             w_scan_start;
  logic             w_scan_adv;
  logic             w_scan_last;
  logic             w_scan_wrap;
  logic             w_scan_state;
  logic [XW-1:0]    w_scan_x;
  logic [YW-1:0]    w_scan_y;
  cmd_t             w_cmd;

  assign w_accept     = (r_state == S_IDLE) && i_op_valid;
  assign w_in_range   = (32'(i_op_x) < 32'(ARR_W)) && (32'(i_op_y) < 32'(ARR_H));
  assign w_lat_done   = (r_lat == LAT_W'(READ_LAT - 1));
  assign w_scan_start = w_accept && (i_op_code == OP_SCAN);
  assign w_scan_adv   = (r_state == S_SCAN_OUT) && i_rd_ready;
  assign w_scan_state = (r_state == S_SCAN_ADDR) || (r_state == S_SCAN_WAIT) ||
                        (r_state == S_SCAN_OUT);

  // A generation ends on its last settle cycle, or on the step itself when there is no settling.
  assign w_gen_done = ((r_state == S_STEP) && (SETTLE == 0)) ||
                      ((r_state == S_SETTLE) && (r_set == SET_W'(SETTLE)));

  life_scan_addr #(
    .ARR_W (ARR_W),
    .ARR_H (ARR_H)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_scan_start),
    .i_advance (w_scan_adv),
    .o_x       (w_scan_x),
    .o_y       (w_scan_y),
    .o_last    (w_scan_last),
    .o_wrap    (w_scan_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_bit   <= 1'b0;
      r_ok    <= 1'b0;
      r_rem   <= '0;
      r_lat   <= '0;
      r_set   <= '0;
      r_gen   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_op_valid) begin
            r_x   <= i_op_x;
            r_y   <= i_op_y;
            r_bit <= i_op_data[0];
            r_rem <= i_op_data;
            r_ok  <= w_in_range && ((i_op_code == OP_WRITE) || (i_op_code == OP_READ));
            // RUN of zero and unknown codes borrow the WRITE slot with r_ok clear: one quiet cycle.
            case (i_op_code)
              OP_CLEAR: r_state <= S_CLEAR;
              OP_WRITE: r_state <= S_WRITE;
              OP_READ:  r_state <= S_RD_ADDR;
              OP_RUN:   r_state <= (i_op_data == '0) ? S_WRITE : S_STEP;
              OP_SCAN:  r_state <= S_SCAN_ADDR;
              default:  r_state <= S_WRITE;
            endcase
          end
        end
        S_CLEAR: begin
          r_gen   <= '0;
          r_state <= S_IDLE;
        end
        S_WRITE: r_state <= S_IDLE;
        S_RD_ADDR: begin
          r_lat   <= LAT_W'(1);
          r_state <= (READ_LAT == 1) ? S_RD_OUT : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (w_lat_done) r_state <= S_RD_OUT;
          else            r_lat   <= r_lat + LAT_W'(1);
        end
        S_RD_OUT: if (i_rd_ready) r_state <= S_IDLE;
        S_STEP: begin
          if (SETTLE != 0) begin
            r_set   <= SET_W'(1);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: if (!w_gen_done) r_set <= r_set + SET_W'(1);
        S_SCAN_ADDR: begin
          r_lat   <= LAT_W'(1);
          r_state <= (READ_LAT == 1) ? S_SCAN_OUT : S_SCAN_WAIT;
        end
        S_SCAN_WAIT: begin
          if (w_lat_done) r_state <= S_SCAN_OUT;
          else            r_lat   <= r_lat + LAT_W'(1);
        end
        S_SCAN_OUT: if (i_rd_ready) r_state <= w_scan_wrap ? S_IDLE : S_SCAN_ADDR;
        default: r_state <= S_IDLE;
      endcase

      if (w_gen_done) begin
        r_gen   <= r_gen + GEN_W'(1);
        r_rem   <= r_rem - GEN_W'(1);
        r_state <= (i_stop || (r_rem == GEN_W'(1))) ? S_IDLE : S_STEP;
      end
    end
  end

  always_comb begin
    w_cmd = CMD_IDLE;
    case (r_state)
      S_CLEAR: w_cmd = CMD_CLEAR;
      S_WRITE: if (r_ok) w_cmd = CMD_WRITE;
      S_STEP:  w_cmd = CMD_STEP;
      default: w_cmd = CMD_IDLE;
    endcase
  end

  assign o_arr_cmd      = w_cmd;
  assign o_arr_adr_x    = w_scan_state ? w_scan_x : r_x;
  assign o_arr_adr_y    = w_scan_state ? w_scan_y : r_y;
  assign o_arr_state_in = (r_state == S_WRITE) && r_ok && r_bit;

  // The address stays applied through the output state, so the array output is stable under stall.
  assign o_rd_valid = (r_state == S_RD_OUT) || (r_state == S_SCAN_OUT);
  assign o_rd_data  = ((r_state == S_RD_OUT) && r_ok && i_arr_state_out) ||
                      ((r_state == S_SCAN_OUT) && i_arr_state_out);
  assign o_rd_last  = (r_state == S_RD_OUT) || ((r_state == S_SCAN_OUT) && w_scan_last);

  assign o_op_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_gen_count = r_gen;

endmodule
`default_nettype wire

// File: tb/tb_life_ctrl.sv
`default_nettype none
// tb_life_ctrl -- directed bench for life_ctrl driving a behavioural 8x8 Life array (READ_LAT=1).
module tb_life_ctrl;
  import life_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [2:0]  op_x = 3'd0;
  logic [2:0]  op_y = 3'd0;
  logic [15:0] op_data = 16'd0;
  logic        stop = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        rd_data;
  logic        rd_last;
  logic        busy;
  logic [15:0] gen_count;
  logic [1:0]  arr_cmd;
  logic [2:0]  adr_x;
  logic [2:0]  adr_y;
  logic        arr_state_in;
  logic        arr_out = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int step_cnt = 0;
  int clear_cnt = 0;

  logic board [0:7][0:7];
  logic nxt   [0:7][0:7];

  life_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_op_valid      (op_valid),
    .o_op_ready      (op_ready),
    .i_op_code       (op_code),
    .i_op_x          (op_x),
    .i_op_y          (op_y),
    .i_op_data       (op_data),
    .i_stop          (stop),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_rd_data       (rd_data),
    .o_rd_last       (rd_last),
    .o_busy          (busy),
    .o_gen_count     (gen_count),
    .o_arr_cmd       (arr_cmd),
    .o_arr_adr_x     (adr_x),
    .o_arr_adr_y     (adr_y),
    .o_arr_state_in  (arr_state_in),
    .i_arr_state_out (arr_out)
  );

  always #5 clk = ~clk;

  // Next Life generation with dead cells beyond the edges.
  always_comb begin
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
              n += int'(board[y+dy][x+dx]);
        nxt[y][x] = (n == 3) || (n == 2 && board[y][x]);
      end
    end
  end

  always @(posedge clk) begin
    arr_out <= board[adr_y][adr_x];
    case (arr_cmd)
      2'd1: board[adr_y][adr_x] <= arr_state_in;
      2'd2: begin board <= nxt; step_cnt <= step_cnt + 1; end
      2'd3: begin
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) board[y][x] <= 1'b0;
        clear_cnt <= clear_cnt + 1;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op, waits (bounded) for op_ready, returns one cycle after acceptance (cycle T+1).
  task automatic do_op(input logic [2:0] code, input logic [2:0] x, input logic [2:0] y,
                       input logic [15:0] data);
    int waited;
    waited = 0;
    op_valid = 1'b1; op_code = code; op_x = x; op_y = y; op_data = data;
    while (!op_ready && waited < 200) begin tick(); waited++; end
    n_checks++; if (op_ready !== 1'b1) $display("FAIL op_accept_timeout code=%0d got ready=%b exp 1", code, op_ready); else n_pass++;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL rst_op_ready got %b exp 1", op_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (arr_cmd !== 2'd0) $display("FAIL rst_cmd got %0d exp 0", arr_cmd); else n_pass++;
    n_checks++; if ({adr_x, adr_y} !== 6'd0) $display("FAIL rst_adr got %0d,%0d exp 0,0", adr_x, adr_y); else n_pass++;
    n_checks++; if (arr_state_in !== 1'b0) $display("FAIL rst_state_in got %b exp 0", arr_state_in); else n_pass++;
    n_checks++; if ({rd_valid, rd_data, rd_last} !== 3'b000) $display("FAIL rst_rd got %b%b%b exp 000", rd_valid, rd_data, rd_last); else n_pass++;
    n_checks++; if (gen_count !== 16'd0) $display("FAIL rst_gen got %0d exp 0", gen_count); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    int c0;
    c0 = clear_cnt;
    do_op(OP_CLEAR, 3'd0, 3'd0, 16'd0);
    n_checks++; if (arr_cmd !== 2'd3) $display("FAIL clear_cmd_t1 got %0d exp 3", arr_cmd); else n_pass++;
    tick();
    n_checks++; if (arr_cmd !== 2'd0) $display("FAIL clear_cmd_t2 got %0d exp 0", arr_cmd); else n_pass++;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL clear_ready_t2 got %b exp 1", op_ready); else n_pass++;
    n_checks++; if (gen_count !== 16'd0) $display("FAIL clear_gen got %0d exp 0", gen_count); else n_pass++;
    tick();
    n_checks++; if (clear_cnt - c0 !== 1) $display("FAIL clear_pulses got %0d exp 1", clear_cnt - c0); else n_pass++;
  endtask

  task automatic test_write_read();
    rd_ready = 1'b1;
    do_op(OP_WRITE, 3'd2, 3'd3, 16'd1);
    n_checks++; if (arr_cmd !== 2'd1) $display("FAIL wr_cmd got %0d exp 1", arr_cmd); else n_pass++;
    n_checks++; if ({adr_x, adr_y} !== {3'd2, 3'd3}) $display("FAIL wr_adr got %0d,%0d exp 2,3", adr_x, adr_y); else n_pass++;
    n_checks++; if (arr_state_in !== 1'b1) $display("FAIL wr_state_in got %b exp 1", arr_state_in); else n_pass++;
    tick();
    n_checks++; if (op_ready !== 1'b1 || arr_cmd !== 2'd0) $display("FAIL wr_done got ready=%b cmd=%0d exp 1,0", op_ready, arr_cmd); else n_pass++;
    do_op(OP_READ, 3'd2, 3'd3, 16'd0);
    n_checks++; if (rd_valid !== 1'b0 || arr_cmd !== 2'd0) $display("FAIL rd_t1 got valid=%b cmd=%0d exp 0,0", rd_valid, arr_cmd); else n_pass++;
    n_checks++; if ({adr_x, adr_y} !== {3'd2, 3'd3}) $display("FAIL rd_adr got %0d,%0d exp 2,3", adr_x, adr_y); else n_pass++;
    tick();
    n_checks++; if ({rd_valid, rd_data, rd_last} !== 3'b111) $display("FAIL rd_beat got %b%b%b exp 111", rd_valid, rd_data, rd_last); else n_pass++;
    tick();
    n_checks++; if (rd_valid !== 1'b0 || op_ready !== 1'b1) $display("FAIL rd_done got valid=%b ready=%b exp 0,1", rd_valid, op_ready); else n_pass++;
    rd_ready = 1'b0;
    do_op(OP_READ, 3'd0, 3'd0, 16'd0);
    tick(); tick();
    n_checks++; if ({rd_valid, rd_data, rd_last} !== 3'b101) $display("FAIL rd_stall got %b%b%b exp 101", rd_valid, rd_data, rd_last); else n_pass++;
    rd_ready = 1'b1;
    tick();
    n_checks++; if (op_ready !== 1'b1) $display("FAIL rd_stall_done got %b exp 1", op_ready); else n_pass++;
  endtask

  task automatic test_run_blinker();
    int s0;
    do_op(OP_CLEAR, 3'd0, 3'd0, 16'd0); tick();
    do_op(OP_WRITE, 3'd3, 3'd4, 16'd1); tick();
    do_op(OP_WRITE, 3'd4, 3'd4, 16'd1); tick();
    do_op(OP_WRITE, 3'd5, 3'd4, 16'd1); tick();
    s0 = step_cnt;
    do_op(OP_RUN, 3'd0, 3'd0, 16'd2);
    n_checks++; if (arr_cmd !== 2'd2 || busy !== 1'b1) $display("FAIL run_t1 got cmd=%0d busy=%b exp 2,1", arr_cmd, busy); else n_pass++;
    tick();
    n_checks++; if (arr_cmd !== 2'd0) $display("FAIL run_t2 got cmd=%0d exp 0", arr_cmd); else n_pass++;
    tick();
    n_checks++; if (arr_cmd !== 2'd0 || gen_count !== 16'd0) $display("FAIL run_t3 got cmd=%0d gen=%0d exp 0,0", arr_cmd, gen_count); else n_pass++;
    tick();
    n_checks++; if (arr_cmd !== 2'd2 || gen_count !== 16'd1) $display("FAIL run_t4 got cmd=%0d gen=%0d exp 2,1", arr_cmd, gen_count); else n_pass++;
    tick(); tick();
    n_checks++; if (busy !== 1'b1 || gen_count !== 16'd1) $display("FAIL run_t6 got busy=%b gen=%0d exp 1,1", busy, gen_count); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || op_ready !== 1'b1 || gen_count !== 16'd2) $display("FAIL run_t7 got busy=%b ready=%b gen=%0d exp 0,1,2", busy, op_ready, gen_count); else n_pass++;
    n_checks++; if (step_cnt - s0 !== 2) $display("FAIL run_steps got %0d exp 2", step_cnt - s0); else n_pass++;
  endtask

  task automatic test_scan();
    int beats, g;
    logic tg, stalled, p_d;
    logic [2:0] p_x, p_y, ex, ey;
    logic exp_d;
    beats = 0; g = 0; tg = 1'b0; stalled = 1'b0; p_d = 1'b0; p_x = '0; p_y = '0;
    rd_ready = 1'b0;
    do_op(OP_SCAN, 3'd0, 3'd0, 16'd0);
    while (beats < 64 && g < 800) begin
      tg = ~tg;
      rd_ready = tg;
      if (rd_valid) begin
        if (stalled) begin
          n_checks++; if ({adr_x, adr_y, rd_data} !== {p_x, p_y, p_d}) $display("FAIL scan_hold beat=%0d got %0d,%0d,%b exp %0d,%0d,%b", beats, adr_x, adr_y, rd_data, p_x, p_y, p_d); else n_pass++;
        end
        if (rd_ready) begin
          ex = 3'(beats % 8); ey = 3'(beats / 8);
          exp_d = (ey == 3'd4) && (ex >= 3'd3) && (ex <= 3'd5);
          n_checks++; if ({adr_x, adr_y} !== {ex, ey}) $display("FAIL scan_adr beat=%0d got %0d,%0d exp %0d,%0d", beats, adr_x, adr_y, ex, ey); else n_pass++;
          n_checks++; if (rd_data !== exp_d) $display("FAIL scan_data beat=%0d got %b exp %b", beats, rd_data, exp_d); else n_pass++;
          n_checks++; if (rd_last !== (beats == 63)) $display("FAIL scan_last beat=%0d got %b exp %b", beats, rd_last, beats == 63); else n_pass++;
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; p_x = adr_x; p_y = adr_y; p_d = rd_data;
        end
      end
      tick();
      g++;
    end
    n_checks++; if (beats !== 64) $display("FAIL scan_beats got %0d exp 64", beats); else n_pass++;
    n_checks++; if (op_ready !== 1'b1 || rd_valid !== 1'b0) $display("FAIL scan_done got ready=%b valid=%b exp 1,0", op_ready, rd_valid); else n_pass++;
    rd_ready = 1'b1;
  endtask

  task automatic test_run_stop();
    int s0, g;
    do_op(OP_CLEAR, 3'd0, 3'd0, 16'd0); tick();
    s0 = step_cnt; g = 0;
    do_op(OP_RUN, 3'd0, 3'd0, 16'd100);
    while (!op_ready && g < 400) begin
      if (step_cnt - s0 >= 3) stop = 1'b1;
      tick(); g++;
    end
    stop = 1'b0;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL stop_timeout got ready=%b exp 1", op_ready); else n_pass++;
    n_checks++; if (step_cnt - s0 !== 3) $display("FAIL stop_steps got %0d exp 3", step_cnt - s0); else n_pass++;
    n_checks++; if (gen_count !== 16'd3) $display("FAIL stop_gen got %0d exp 3", gen_count); else n_pass++;
    // stop held from the start still lets the first step through
    s0 = step_cnt; g = 0; stop = 1'b1;
    do_op(OP_RUN, 3'd0, 3'd0, 16'd5);
    while (!op_ready && g < 100) begin tick(); g++; end
    stop = 1'b0;
    n_checks++; if (step_cnt - s0 !== 1 || gen_count !== 16'd4) $display("FAIL stop_early got steps=%0d gen=%0d exp 1,4", step_cnt - s0, gen_count); else n_pass++;
    s0 = step_cnt;
    do_op(OP_RUN, 3'd0, 3'd0, 16'd0);
    n_checks++; if (arr_cmd !== 2'd0 || busy !== 1'b1) $display("FAIL run0_t1 got cmd=%0d busy=%b exp 0,1", arr_cmd, busy); else n_pass++;
    tick();
    n_checks++; if (op_ready !== 1'b1 || step_cnt - s0 !== 0 || gen_count !== 16'd4) $display("FAIL run0_t2 got ready=%b steps=%0d gen=%0d exp 1,0,4", op_ready, step_cnt - s0, gen_count); else n_pass++;
    do_op(3'd6, 3'd1, 3'd1, 16'd1);
    n_checks++; if (arr_cmd !== 2'd0 || busy !== 1'b1) $display("FAIL undef_t1 got cmd=%0d busy=%b exp 0,1", arr_cmd, busy); else n_pass++;
    tick();
    n_checks++; if (op_ready !== 1'b1) $display("FAIL undef_t2 got ready=%b exp 1", op_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int beats, g;
    logic hit;
    beats = 0; g = 0; hit = 1'b0;
    rd_ready = 1'b1;
    do_op(OP_SCAN, 3'd0, 3'd0, 16'd0);
    while (!hit && g < 200) begin
      if (rd_valid) begin
        if (beats == 9) begin
          rst_n = 1'b0; hit = 1'b1;
        end
        beats++;
      end
      if (!hit) begin tick(); g++; end
    end
    #1;
    n_checks++; if (hit !== 1'b1) $display("FAIL rst_scan_reach got beats=%0d exp 10", beats); else n_pass++;
    n_checks++; if (arr_cmd !== 2'd0 || rd_valid !== 1'b0) $display("FAIL rst_scan_now got cmd=%0d valid=%b exp 0,0", arr_cmd, rd_valid); else n_pass++;
    n_checks++; if (op_ready !== 1'b1 || gen_count !== 16'd0) $display("FAIL rst_scan_ready got ready=%b gen=%0d exp 1,0", op_ready, gen_count); else n_pass++;
    tick(); tick();
    n_checks++; if (arr_cmd !== 2'd0 || busy !== 1'b0) $display("FAIL rst_scan_hold got cmd=%0d busy=%b exp 0,0", arr_cmd, busy); else n_pass++;
    rst_n = 1'b1;
    tick();
    do_op(OP_WRITE, 3'd6, 3'd1, 16'd1); tick();
    do_op(OP_READ, 3'd6, 3'd1, 16'd0);
    tick();
    n_checks++; if ({rd_valid, rd_data, rd_last} !== 3'b111) $display("FAIL rst_read_beat got %b%b%b exp 111", rd_valid, rd_data, rd_last); else n_pass++;
    tick();
    n_checks++; if (op_ready !== 1'b1) $display("FAIL rst_read_done got %b exp 1", op_ready); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_run_blinker();
    test_scan();
    test_run_stop();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
